// File: rtl/ram64_mover_pkg.sv
// ram64_mover_pkg
// Shared definitions for the 64-word RAM block mover: the controller state
// encoding, the default widths used by the mover and its address generator,
// and the RAM depth.
//
// Optional feature macro used by the mover: RAM64_BLOCK_MOVER_CHECKSUM_EN
// (this package itself is the same in both builds).
package ram64_mover_pkg;

    // Default widths: 6-bit word address (64 words), 16-bit words, and a
    // 7-bit length so that the full-memory length 64 is representable.
    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_LEN_W  = 7;

    // Number of words in the attached RAM; also the largest legal length.
    localparam int MEM_WORDS = 64;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram64_mover_addr_gen.sv
// ram64_mover_addr_gen
// Holds the captured transfer operands (source, destination, length) and the
// word counter, and produces the wrapped source/destination word addresses
// plus a flag marking the final word of the block.
//
// Ports:
//   clk       input   system clock, rising edge
//   rst_n     input   asynchronous active-low reset
//   load      input   capture src/dst/len and clear the counter
//   step      input   advance the counter by one word
//   src       input   [ADDR_W] first source word address
//   dst       input   [ADDR_W] first destination word address
//   len       input   [LEN_W]  already-clamped word count
//   src_addr  output  [ADDR_W] src_r + count, wrapping modulo the RAM depth
//   dst_addr  output  [ADDR_W] dst_r + count, wrapping modulo the RAM depth
//   last      output  high while the current word is the final one
module ram64_mover_addr_gen
    import ram64_mover_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last
);

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count;

    // Operand capture and word counter. A new load always wins over a step
    // so the counter restarts cleanly at zero for each accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            count <= '0;
        end else if (load) begin
            src_r <= src;
            dst_r <= dst;
            len_r <= len;
            count <= '0;
        end else if (step) begin
            count <= count + LEN_W'(1);
        end
    end

    // Address sums are truncated to ADDR_W bits, which gives the modulo-64
    // wrap for free. The counter never exceeds 63 while addresses are in
    // use, so only its low ADDR_W bits matter here.
    always_comb begin
        src_addr = src_r + count[ADDR_W-1:0];
        dst_addr = dst_r + count[ADDR_W-1:0];
        last     = ((count + LEN_W'(1)) == len_r);
    end

endmodule

// File: rtl/ram64_block_mover.sv
// ram64_block_mover
// Memory master that copies a block of words inside the 64x16 RAM, one word
// every two clocks (READ the source word into a holding register, then WRITE
// it to the destination). Copying is strictly ascending, so overlapping
// regions give the forward-copy result.
//
// Optional feature: define RAM64_BLOCK_MOVER_CHECKSUM_EN to add a 16-bit
// 'checksum' output, the modulo-2^16 sum of every word written by the most
// recent transfer.
//
// Ports:
//   clk          input   system clock, rising edge
//   rst_n        input   asynchronous active-low reset
//   start        input   transfer request, only looked at in IDLE
//   src          input   [ADDR_W] first source word address
//   dst          input   [ADDR_W] first destination word address
//   len          input   [LEN_W]  word count, values above 64 clamp to 64
//   busy         output  high while reading or writing
//   done         output  one-cycle completion pulse
//   mem_address  output  [ADDR_W] RAM word address
//   mem_in       output  [DATA_W] RAM write data
//   mem_load     output  RAM write enable
//   mem_out      input   [DATA_W] RAM read data (combinational on address)
//   checksum     output  [DATA_W] only with RAM64_BLOCK_MOVER_CHECKSUM_EN
module ram64_block_mover
    import ram64_mover_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] hold;
    logic              accept;
    logic [LEN_W-1:0]  len_clamped;
    logic              len_is_zero;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              last;

    // A request is taken only in IDLE; the length is clamped before it is
    // captured so the address generator never sees more than a full RAM.
    always_comb begin
        accept      = (state == IDLE) && start;
        len_clamped = (len > LEN_W'(MEM_WORDS)) ? LEN_W'(MEM_WORDS) : len;
        len_is_zero = (len_clamped == '0);
    end

    ram64_mover_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state == WRITE),
        .src      (src),
        .dst      (dst),
        .len      (len_clamped),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    // State register. Because every RAM-facing output is decoded from this
    // register, an asynchronous reset removes mem_load immediately and no
    // write can land on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding register: the word read in READ is written back in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (state == READ) begin
            hold <= mem_out;
        end
    end

    // Next-state and output decode. Outside READ/WRITE the RAM side is
    // parked at address 0 with zero write data.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = len_is_zero ? DONE : READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_addr;
                state_next  = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_address = dst_addr;
                mem_in      = hold;
                mem_load    = 1'b1;
                state_next  = last ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
    // Running sum of written words. Cleared on accept, so after done it holds
    // the total for the finished block until the next request is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum + hold;
        end
    end
`endif

endmodule

// File: tb/tb_ram64_block_mover.sv
// tb_ram64_block_mover
// Directed bench for ram64_block_mover with a behavioural 64x16 RAM. Each
// transfer pushes the full expected RAM image (from a forward-copy reference
// model) onto a scoreboard queue; the queue is drained against the RAM once
// the mover reports done. Define RAM64_BLOCK_MOVER_CHECKSUM_EN to also check
// the checksum output.
module tb_ram64_block_mover;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic [5:0]  mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    ram64_block_mover dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with a bench-side preload port; one process owns it.
    logic [15:0] ram [64];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;

    assign mem_out = ram[mem_address];

    always @(posedge clk) begin
        if (mem_load) begin
            ram[mem_address] <= mem_in;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
    end

    // Reference memory image and scoreboard of expected RAM words.
    typedef struct {
        int          addr;
        logic [15:0] data;
    } exp_t;

    logic [15:0] model_mem [64];
    exp_t        exp_q[$];
    int          vectors;
    int          miscompares;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int addr, input logic [15:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = addr[5:0];
        pre_data = data;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        model_mem[addr] = data;
    endtask

    // Forward copy on the reference image, then queue the whole image.
    task automatic pushExpected(input int s, input int d, input int l);
        int eff;
        eff = (l > 64) ? 64 : l;
        for (int i = 0; i < eff; i++) begin
            model_mem[(d + i) % 64] = model_mem[(s + i) % 64];
        end
        for (int a = 0; a < 64; a++) begin
            exp_q.push_back('{addr: a, data: model_mem[a]});
        end
    endtask

    task automatic drainScoreboard(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s ram[%0d]", tag, e.addr), {16'h0, ram[e.addr]}, {16'h0, e.data});
        end
    endtask

    // Drive one request and follow it to done. latency counts cycles from the
    // accept edge to the done-high cycle (-1 on timeout). If disturb is
    // nonzero, start is pulsed with junk operands during that cycle.
    task automatic applyStimulus(input logic [5:0] s, input logic [5:0] d,
                                 input logic [6:0] l, input int disturb,
                                 output int latency, output int loads,
                                 output logic busy_at_done);
        latency      = -1;
        loads        = 0;
        busy_at_done = 1'bx;
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src   = 6'd0;
        dst   = 6'd0;
        len   = 7'd0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (mem_load) loads++;
            if (done) begin
                latency      = cyc;
                busy_at_done = busy;
                break;
            end
            if (cyc == disturb) begin
                start = 1'b1;
                src   = 6'd40;
                dst   = 6'd1;
                len   = 7'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic runCopy(input string tag, input logic [5:0] s, input logic [5:0] d,
                           input logic [6:0] l, input int disturb);
        int   latency;
        int   loads;
        int   eff;
        logic b;
        eff = (l > 7'd64) ? 64 : int'(l);
        pushExpected(s, d, eff);
        applyStimulus(s, d, l, disturb, latency, loads, b);
        checkOutput({tag, " latency"}, latency, 2 * eff + 1);
        checkOutput({tag, " mem_load count"}, loads, eff);
        checkOutput({tag, " busy at done"}, {31'h0, b}, 32'h0);
        @(posedge clk);
        #1;
        drainScoreboard(tag);
    endtask

    initial begin
        int latency;
        int loads;
        logic b;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        src         = '0;
        dst         = '0;
        len         = '0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;

        // Reset state, while the RAM is filled with random words.
        #2;
        checkOutput("reset busy", {31'h0, busy}, 0);
        checkOutput("reset done", {31'h0, done}, 0);
        checkOutput("reset mem_load", {31'h0, mem_load}, 0);
        checkOutput("reset mem_address", {26'h0, mem_address}, 0);
        checkOutput("reset mem_in", {16'h0, mem_in}, 0);
`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
        checkOutput("reset checksum", {16'h0, checksum}, 0);
`endif
        for (int a = 0; a < 64; a++) begin
            preload(a, 16'($urandom));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy.
        preload(10, 16'h1111);
        preload(11, 16'h2222);
        preload(12, 16'h3333);
        preload(13, 16'h4444);
        runCopy("basic", 6'd10, 6'd40, 7'd4, 0);
`ifdef RAM64_BLOCK_MOVER_CHECKSUM_EN
        checkOutput("basic checksum", {16'h0, checksum}, 32'hAAAA);
`endif

        // Zero length.
        runCopy("len0", 6'd5, 6'd6, 7'd0, 0);

        // Wrap-around on the source, then on the destination.
        preload(62, 16'hAAAA);
        preload(63, 16'hBBBB);
        preload(0, 16'hCCCC);
        runCopy("wrap src", 6'd62, 6'd20, 7'd3, 0);
        runCopy("wrap dst", 6'd20, 6'd63, 7'd2, 0);

        // Overlapping forward copy.
        preload(0, 16'd1);
        preload(1, 16'd2);
        preload(2, 16'd3);
        preload(3, 16'd4);
        runCopy("overlap", 6'd0, 6'd1, 7'd3, 0);

        // Start pulsed during READ is ignored.
        runCopy("start while busy", 6'd3, 6'd50, 7'd2, 1);

        // Reset during the third WRITE: only two destination words change.
        for (int i = 0; i < 8; i++) begin
            preload(48 + i, 16'h5A00 + 16'(i));
        end
        pushExpected(48, 8, 2);
        @(negedge clk);
        src   = 6'd48;
        dst   = 6'd8;
        len   = 7'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 2; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("third WRITE mem_load", {31'h0, mem_load}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-op reset mem_load", {31'h0, mem_load}, 0);
        checkOutput("mid-op reset busy", {31'h0, busy}, 0);
        checkOutput("mid-op reset mem_address", {26'h0, mem_address}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        drainScoreboard("mid-op reset");
        runCopy("after reset", 6'd30, 6'd31, 7'd1, 0);

        // Length clamp: 100 behaves as 64.
        for (int a = 0; a < 8; a++) begin
            preload(a, 16'hC000 + 16'(a));
        end
        runCopy("clamp", 6'd0, 6'd32, 7'd100, 0);

        // The explicit latency/loads path, used once with the raw outputs.
        applyStimulus(6'd1, 6'd2, 7'd0, 0, latency, loads, b);
        checkOutput("len0 repeat latency", latency, 1);
        checkOutput("len0 repeat mem_load count", loads, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
